// File: rtl/seq_detect_param.sv
// seq_detect_param: serial bit-pattern detector with programmable pattern,
// length and overlap mode, selectable Mealy/Moore match output and a
// saturating match counter.
module seq_detect_param #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned MEALY   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ip,
    input  logic               ip_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [3:0]         len,
    input  logic               overlap,
    output logic               op,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cnt_sat,
    output logic               cfg_err
);

    localparam logic [3:0]       FILL_MAX = 4'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [MAX_LEN-1:0] pat_r;
    logic [3:0]         len_r;
    logic               ovl_r;
    logic [MAX_LEN-1:0] hist;
    logic [3:0]         fill;
    logic               op_r;

    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] mask;
    logic               fill_ok;
    logic               hit;

    // Compare the newest len_r bits (history plus the bit on the wire) to the pattern.
    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < 32'(len_r));
        end
        window  = {hist[MAX_LEN-2:0], ip};
        fill_ok = (({1'b0, fill} + 5'd1) >= {1'b0, len_r});
        // A load on the same edge discards the bit, so it can never count as a hit.
        hit     = ip_valid && !cfg_load && !cfg_err && fill_ok &&
                  (((window ^ pat_r) & mask) == '0);
    end

    // Configuration, history, fill level, counter and registered match flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_r     <= '0;
            len_r     <= '0;
            ovl_r     <= 1'b0;
            hist      <= '0;
            fill      <= '0;
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
            cfg_err   <= 1'b1;
            op_r      <= 1'b0;
        end else if (cfg_load) begin
            pat_r     <= pattern;
            len_r     <= len;
            ovl_r     <= overlap;
            hist      <= '0;
            fill      <= '0;
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
            cfg_err   <= (len == 4'd0) || (len > FILL_MAX);
            op_r      <= 1'b0;
        end else begin
            op_r <= hit;
            if (ip_valid) begin
                if (hit && !ovl_r) begin
                    hist <= '0;
                    fill <= '0;
                end else begin
                    hist <= window;
                    if (fill != FILL_MAX) begin
                        fill <= fill + 4'd1;
                    end
                end
            end
            if (hit && (match_cnt != CNT_MAX)) begin
                match_cnt <= match_cnt + CNT_W'(1);
                if (match_cnt == (CNT_MAX - CNT_W'(1))) begin
                    cnt_sat <= 1'b1;
                end
            end
        end
    end

    assign op = (MEALY != 0) ? hit : op_r;

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial bit-pattern detector, the successor to the fixed 1011 Mealy detector. Pattern, length, overlap mode and output style are configurable. It samples a qualified serial bit stream and flags every occurrence of a programmable pattern of 1..MAX_LEN bits. It also keeps a saturating match counter. It sits between a serial front end and the control logic that consumes match events.

## Interface
Parameters:
- MAX_LEN, 8: longest supported pattern, legal range 2..15.
- CNT_W, 8: width of the match counter.
- MEALY, 1: 1 = op is combinational from the current bit (Mealy); 0 = op is registered, one cycle later (Moore).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low.
- ip  in  1  serial data bit.
- ip_valid  in  1  qualifies ip; a bit is consumed only on a clk edge with ip_valid=1.
- cfg_load  in  1  one-cycle pulse; latches pattern, len and overlap, and clears history, fill and counter.
- pattern  in  MAX_LEN  pattern bits; pattern[len-1] is the first bit received and pattern[0] the last.
- len  in  4  pattern length in bits.
- overlap  in  1  1 = overlapping matches allowed; 0 = history cleared after each match.
- op  out  1  match flag.
- match_cnt  out  CNT_W  number of matches since the last reset or cfg_load.
- cnt_sat  out  1  sticky flag, set when match_cnt saturates.
- cfg_err  out  1  latched len is 0 or greater than MAX_LEN; detection disabled.

## Operation
- Registered state:
  - pat_r, len_r, ovl_r: latched configuration.
  - hist: MAX_LEN-bit shift register; new bit enters at bit 0.
  - fill: 0..MAX_LEN, number of valid bits held in hist.
  - match_cnt, cnt_sat, cfg_err.
  - op_r: used only when MEALY=0.
- Reset (rst=0, asynchronous):
  - hist=0, fill=0, match_cnt=0, cnt_sat=0, op=0.
  - pat_r=0, len_r=0, ovl_r=0, so cfg_err=1 after reset.
- cfg_load=1 on a clock edge:
  - latches pattern, len and overlap.
  - clears hist, fill, match_cnt, cnt_sat and op_r.
  - sets cfg_err = (len==0 or len>MAX_LEN).
  - ignores ip on that edge.
- Match condition (hit) on the current cycle: ip_valid=1, cfg_err=0, fill+1 >= len_r, and the low len_r bits of {hist,ip} equal pat_r[len_r-1:0].
- On a valid bit with no hit: hist shifts in ip; fill = min(fill+1, MAX_LEN).
- On a hit:
  - match_cnt increments, saturating at 2^CNT_W-1.
  - cnt_sat is set on the increment that reaches the maximum and stays set.
  - overlap=1: hist shifts in ip and fill updates as normal.
  - overlap=0: hist=0 and fill=0, so the next match needs len_r fresh bits.
- ip_valid=0: no state change; op=0 in Mealy mode.
- Output:
  - MEALY=1: op = hit (combinational).
  - MEALY=0: op_r <= hit, op = op_r.
- Config inputs are sampled only on cfg_load. Changing them between loads has no effect.

## Timing
- Mealy: op is high during the same cycle the last pattern bit is presented with ip_valid=1, before the edge that consumes it. match_cnt updates on that edge.
- Moore: op is high for exactly one cycle after the edge that consumed the last bit. It coincides with the updated match_cnt.
- Consecutive hits give consecutive op pulses, with no dead cycle in overlap mode.
- Minimum spacing between non-overlap matches is len_r valid bits.
- Once match_cnt reaches 2^CNT_W-1 it holds. op still pulses on every hit.
- Reset mid-stream clears everything immediately. Moore op drops asynchronously; Mealy op drops because cfg_err=1.
- cfg_load together with ip_valid: the load wins, the bit is discarded, and no hit is counted.

## Test plan
- Default config, pattern=1011, len=4, overlap=1, MEALY=1. Stream 1,0,1,1,0,1,1 -> op high on bits 4 and 7; match_cnt=2.
- Same stream with overlap=0 -> op high on bit 4 only; match_cnt=1; fill=3 at the end.
- MEALY=0 build, same as the first test -> op is one cycle later than in the Mealy case on both matches. Bubbles with ip_valid=0 inserted between bits do not change the match positions.
- CNT_W=2, pattern=11, len=2, overlap=1. Feed seven 1s -> match_cnt goes 1,2,3,3,3,3; cnt_sat sets on the third hit; op pulses six times.
- len=0, then len=MAX_LEN+1 -> cfg_err=1, op stays 0 for any stream. Reload with len=MAX_LEN and pattern=all-ones -> first hit on the MAX_LEN-th 1.
- Assert rst low mid-pattern (after 1,0,1). Release and send 1 -> no match; all outputs return to their reset values asynchronously; cfg_err=1 until the next cfg_load.
